// File: rtl/dma_priority_arbiter_if.sv
// Bus bundle between the DMA arbiter and its request, mask and command sources and the host handshake.
// Status ports exist only when DMA_ARB_STATUS_EN is defined.
interface dma_priority_arbiter_if #(
   parameter int NCH  = 4,
   parameter int CH_W = 2
);
   logic            cmd_rotate;
   logic            cmd_dreq_high;
   logic            cmd_dack_high;
   logic [NCH-1:0]  mask;
   logic [NCH-1:0]  sw_req;
   logic [NCH-1:0]  DREQ;
   logic            HLDA;
   logic            eop;
   logic            HRQ;
   logic [NCH-1:0]  DACK;
   logic [CH_W-1:0] active_ch;
   logic            grant_valid;
`ifdef DMA_ARB_STATUS_EN
   logic            status_rd;
   logic [NCH-1:0]  status_tc;
`endif

   modport slave (
      input  cmd_rotate, cmd_dreq_high, cmd_dack_high, mask, sw_req, DREQ, HLDA, eop,
`ifdef DMA_ARB_STATUS_EN
      input  status_rd,
      output status_tc,
`endif
      output HRQ, DACK, active_ch, grant_valid
   );

   modport master (
      output cmd_rotate, cmd_dreq_high, cmd_dack_high, mask, sw_req, DREQ, HLDA, eop,
`ifdef DMA_ARB_STATUS_EN
      output status_rd,
      input  status_tc,
`endif
      input  HRQ, DACK, active_ch, grant_valid
   );
endinterface

// File: rtl/dma_priority_arbiter.sv
// N-channel DMA request arbiter (fixed or rotating priority) with HRQ/HLDA hold handshake.
// Define DMA_ARB_STATUS_EN to add the sticky terminal-count status register (status_rd / status_tc).
module dma_priority_arbiter #(
   parameter int NCH  = 4,
   parameter int CH_W = 2
) (
   input  logic                   clk,
   input  logic                   RESET,
   dma_priority_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_HLDA = 2'd1,
      S_SERVICE   = 2'd2,
      S_RELEASE   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [NCH-1:0]  w_req;
   logic [NCH-1:0]  w_hi_mask;
   logic [NCH-1:0]  w_req_hi;
   logic [NCH-1:0]  w_gnt;
   logic [CH_W-1:0] r_active_ch;
   logic [CH_W-1:0] r_last_ch;
   logic [CH_W-1:0] w_winner;
   logic            w_any_req;
   logic            w_eop_done;

   function automatic logic [CH_W-1:0] f_lowest(input logic [NCH-1:0] v);
      f_lowest = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (v[i]) f_lowest = CH_W'(i);
      end
   endfunction

   // Rotating search from last_ch+1 with wrap == lowest request above last_ch, else lowest overall.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         assign w_req[gi]     = ((bus.DREQ[gi] == bus.cmd_dreq_high) & ~bus.mask[gi]) | bus.sw_req[gi];
         assign w_hi_mask[gi] = bus.cmd_rotate && (CH_W'(gi) > r_last_ch);
         assign w_gnt[gi]     = (r_state == S_SERVICE) && (r_active_ch == CH_W'(gi));
      end
   endgenerate

   assign w_req_hi   = w_req & w_hi_mask;
   assign w_any_req  = |w_req;
   assign w_winner   = (|w_req_hi) ? f_lowest(w_req_hi) : f_lowest(w_req);
   assign w_eop_done = (r_state == S_SERVICE) && bus.eop;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:      if (w_any_req) w_state_next = S_WAIT_HLDA;
         S_WAIT_HLDA: begin
            if (bus.HLDA)       w_state_next = S_SERVICE;
            else if (!w_any_req) w_state_next = S_IDLE;
         end
         S_SERVICE: begin
            // End of process wins over a simultaneous loss of the bus.
            if (bus.eop)        w_state_next = S_RELEASE;
            else if (!bus.HLDA) w_state_next = S_IDLE;
         end
         S_RELEASE:   if (!bus.HLDA) w_state_next = S_IDLE;
         default:     w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.HRQ         = (r_state == S_WAIT_HLDA) || (r_state == S_SERVICE);
      bus.grant_valid = (r_state == S_SERVICE);
   end

   assign bus.DACK      = bus.cmd_dack_high ? w_gnt : ~w_gnt;
   assign bus.active_ch = r_active_ch;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_active_ch <= '0;
         r_last_ch   <= CH_W'(NCH - 1);
      end else begin
         if (r_state == S_IDLE && w_any_req) r_active_ch <= w_winner;
         if (w_eop_done && bus.cmd_rotate)   r_last_ch   <= r_active_ch;
      end
   end

`ifdef DMA_ARB_STATUS_EN
   logic [NCH-1:0] r_status_tc;

   // A set in the same cycle as the read-clear survives.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) r_status_tc <= '0;
      else       r_status_tc <= (bus.status_rd ? '0 : r_status_tc) | (w_eop_done ? w_gnt : '0);
   end

   assign bus.status_tc = r_status_tc;
`endif

endmodule
